// File: rtl/mc_datapath_pkg.sv
// Shared types for mc_datapath: opcodes, FSM states, ALU operations and
// instruction field positions derived from the datapath width and register-index width.
package mc_datapath_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SLT  = 4'd4,
      OP_ADDI = 4'd5,
      OP_LW   = 4'd6,
      OP_SW   = 4'd7,
      OP_BEQ  = 4'd8,
      OP_J    = 4'd9,
      OP_MUL  = 4'd10,
      OP_HALT = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_e;

   // Fields below the 4-bit opcode: rs, rt, rd (rw bits each), imm shares rd's bits.
   function automatic int f_rs_lsb(input int n, input int rw);
      return n - 4 - rw;
   endfunction

   function automatic int f_rt_lsb(input int n, input int rw);
      return n - 4 - 2 * rw;
   endfunction

   function automatic int f_rd_lsb(input int n, input int rw);
      return n - 4 - 3 * rw;
   endfunction

   function automatic int f_imm_w(input int n, input int rw);
      return n - 4 - 2 * rw;
   endfunction

   function automatic alu_op_e f_alu_op(input opcode_e op);
      case (op)
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file for mc_datapath: two combinational read ports, one synchronous write port.
// R0 always reads zero and ignores writes; asynchronous reset clears every register.
module mc_regfile #(
   parameter int N    = 16,
   parameter int NREG = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [$clog2(NREG)-1:0] i_ra_addr,
   output logic [N-1:0]            o_ra_data,
   input  logic [$clog2(NREG)-1:0] i_rb_addr,
   output logic [N-1:0]            o_rb_data,
   input  logic                    i_we,
   input  logic [$clog2(NREG)-1:0] i_wa,
   input  logic [N-1:0]            i_wd
);

   logic [N-1:0] r_regs [NREG];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_wa != '0)) begin
         r_regs[i_wa] <= i_wd;
      end
   end

   assign o_ra_data = (i_ra_addr == '0) ? '0 : r_regs[i_ra_addr];
   assign o_rb_data = (i_rb_addr == '0) ? '0 : r_regs[i_rb_addr];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle FETCH/DECODE/EXEC/MEM/WB CPU core on one req/ready memory port.
// Define MC_DATAPATH_MUL_EN to add an iterative shift-add MUL (op 10); otherwise op 10 is illegal.
module mc_datapath
   import mc_datapath_pkg::*;
#(
   parameter int N    = 16,
   parameter int NREG = 8
) (
   input  logic         clk,
   input  logic         reset,
   output logic         mem_req,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata,
   input  logic         mem_ready,
   output logic [N-1:0] pc,
   output logic         retire,
   output logic         halted,
   output logic         err,
   output logic [2:0]   dbg_state
);

   localparam int RW     = $clog2(NREG);
   localparam int RS_LSB = f_rs_lsb(N, RW);
   localparam int RT_LSB = f_rt_lsb(N, RW);
   localparam int RD_LSB = f_rd_lsb(N, RW);
   localparam int IMM_W  = f_imm_w(N, RW);

   state_e        r_state;
   logic [N-1:0]  r_pc, r_ir, r_a, r_b, r_alu_out, r_mdr;
   logic          r_mem_req, r_mem_we, r_retire, r_halted, r_err;
   logic [N-1:0]  r_mem_addr, r_mem_wdata;

   opcode_e       w_op;
   alu_op_e       w_alu_op;
   logic [RW-1:0] w_rs, w_rt, w_rd;
   logic [N-1:0]  w_imm, w_jtarget, w_opnd_b, w_alu, w_br_pc;
   logic [N-1:0]  w_rs_data, w_rt_data, w_rf_wd;
   logic [RW-1:0] w_rf_wa;
   logic          w_rf_we, w_use_imm, w_is_rtype, w_legal;

   assign w_op      = opcode_e'(r_ir[N-1:N-4]);
   assign w_alu_op  = f_alu_op(w_op);
   assign w_rs      = r_ir[RS_LSB +: RW];
   assign w_rt      = r_ir[RT_LSB +: RW];
   assign w_rd      = r_ir[RD_LSB +: RW];
   assign w_imm     = {{(N-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
   assign w_jtarget = {4'b0000, r_ir[N-5:0]};
   assign w_use_imm = (w_op == OP_ADDI) || (w_op == OP_LW) || (w_op == OP_SW);
   assign w_is_rtype = (r_ir[N-1:N-4] <= 4'd4) || (w_op == OP_MUL);
   assign w_opnd_b  = w_use_imm ? w_imm : r_b;
   // pc already points past the branch when EXEC runs, so the offset is relative to pc+1.
   assign w_br_pc   = (r_a == r_b) ? (r_pc + w_imm) : r_pc;

`ifdef MC_DATAPATH_MUL_EN
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] MUL_LAST = CW'(N - 1);
   logic [N-1:0]  r_mul_a, r_mul_b, r_mul_acc;
   logic [CW-1:0] r_mul_cnt;
   logic [N-1:0]  w_mul_acc_next;
   assign w_mul_acc_next = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);
   assign w_legal = (r_ir[N-1:N-4] <= 4'd10);
`else
   assign w_legal = (r_ir[N-1:N-4] <= 4'd9);
`endif

   always_comb begin
      w_alu = r_a + w_opnd_b;
      case (w_alu_op)
         ALU_SUB: w_alu = r_a - w_opnd_b;
         ALU_AND: w_alu = r_a & w_opnd_b;
         ALU_OR:  w_alu = r_a | w_opnd_b;
         ALU_SLT: w_alu = {{(N-1){1'b0}}, ($signed(r_a) < $signed(w_opnd_b))};
         default: w_alu = r_a + w_opnd_b;
      endcase
   end

   // Only R-type, ADDI and LW ever reach WB, so WB alone qualifies the write.
   assign w_rf_we = (r_state == S_WB);
   assign w_rf_wa = w_is_rtype ? w_rd : w_rt;
   assign w_rf_wd = (w_op == OP_LW) ? r_mdr : r_alu_out;

   mc_regfile #(.N(N), .NREG(NREG)) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .i_ra_addr (w_rs),
      .o_ra_data (w_rs_data),
      .i_rb_addr (w_rt),
      .o_rb_data (w_rt_data),
      .i_we      (w_rf_we),
      .i_wa      (w_rf_wa),
      .i_wd      (w_rf_wd)
   );

   // Memory handshake: a request (mem_req with mem_we/mem_addr/mem_wdata) is held unchanged
   // until an edge samples mem_ready=1; that edge completes it. mem_ready is ignored while
   // mem_req=0. A SW completion arms the next fetch directly, so that request starts at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_FETCH;
         r_pc        <= '0;
         r_ir        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_alu_out   <= '0;
         r_mdr       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_retire    <= 1'b0;
         r_halted    <= 1'b0;
         r_err       <= 1'b0;
`ifdef MC_DATAPATH_MUL_EN
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_mul_acc   <= '0;
         r_mul_cnt   <= '0;
`endif
      end else begin
         r_retire <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (!r_mem_req) begin
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= r_pc;
               end else if (mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_ir      <= mem_rdata;
                  r_pc      <= r_pc + N'(1);
                  r_state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_a <= w_rs_data;
               r_b <= w_rt_data;
`ifdef MC_DATAPATH_MUL_EN
               r_mul_a   <= w_rs_data;
               r_mul_b   <= w_rt_data;
               r_mul_acc <= '0;
               r_mul_cnt <= '0;
`endif
               if (w_op == OP_HALT) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else if (!w_legal) begin
                  r_halted <= 1'b1;
                  r_err    <= 1'b1;
                  r_state  <= S_HALT;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (w_op)
                  OP_BEQ: begin
                     r_pc       <= w_br_pc;
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= w_br_pc;
                     r_retire   <= 1'b1;
                     r_state    <= S_FETCH;
                  end
                  OP_J: begin
                     r_pc       <= w_jtarget;
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= w_jtarget;
                     r_retire   <= 1'b1;
                     r_state    <= S_FETCH;
                  end
                  OP_LW, OP_SW: begin
                     r_alu_out   <= w_alu;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= (w_op == OP_SW);
                     r_mem_addr  <= w_alu;
                     r_mem_wdata <= r_b;
                     r_state     <= S_MEM;
                  end
`ifdef MC_DATAPATH_MUL_EN
                  OP_MUL: begin
                     r_mul_acc <= w_mul_acc_next;
                     r_mul_a   <= r_mul_a << 1;
                     r_mul_b   <= r_mul_b >> 1;
                     r_mul_cnt <= r_mul_cnt + CW'(1);
                     if (r_mul_cnt == MUL_LAST) begin
                        r_alu_out <= w_mul_acc_next;
                        r_state   <= S_WB;
                     end
                  end
`endif
                  default: begin
                     r_alu_out <= w_alu;
                     r_state   <= S_WB;
                  end
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (w_op == OP_SW) begin
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= r_pc;
                     r_retire   <= 1'b1;
                     r_state    <= S_FETCH;
                  end else begin
                     r_mdr     <= mem_rdata;
                     r_mem_req <= 1'b0;
                     r_state   <= S_WB;
                  end
               end
            end
            S_WB: begin
               r_mem_req  <= 1'b1;
               r_mem_we   <= 1'b0;
               r_mem_addr <= r_pc;
               r_retire   <= 1'b1;
               r_state    <= S_FETCH;
            end
            default: begin
               r_state <= S_HALT;
            end
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign pc        = r_pc;
   assign retire    = r_retire;
   assign halted    = r_halted;
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule
